// File: rtl/cp0_reg.sv
// MIPS-style coprocessor 0: BadVAddr, Count/Compare timer, Status, Cause and EPC,
// plus exception/ERET arbitration that drives the pipeline flush request to CTRL.
module cp0_reg #(
  parameter logic [31:0] EXC_ENTRY      = 32'hBFC0_0380,
  parameter int          CP0_TO_CTRL_WD = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_valid,
  input  logic [31:0]               pc,
  input  logic                      in_delayslot,
  input  logic                      exc_adel_if,
  input  logic                      exc_ri,
  input  logic                      exc_ov,
  input  logic                      exc_sys,
  input  logic                      exc_bp,
  input  logic                      exc_adel_ld,
  input  logic                      exc_ades,
  input  logic [31:0]               bad_addr,
  input  logic                      eret,
  input  logic                      mtc0_we,
  input  logic [4:0]                waddr,
  input  logic [31:0]               wdata,
  input  logic [4:0]                raddr,
  output logic [31:0]               rdata,
  input  logic [5:0]                ext_int,
  output logic [CP0_TO_CTRL_WD-1:0] cp0_to_ctrl_bus
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  typedef enum logic [3:0] {
    SRC_NONE, SRC_INT, SRC_ADEL_IF, SRC_RI, SRC_OV,
    SRC_SYS, SRC_BP, SRC_ADEL_LD, SRC_ADES
  } exc_src_e;

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic        tick;
  logic [31:0] compare;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc_code;
  logic [31:0] epc;

  exc_src_e    exc_src;
  logic [4:0]  exc_code;
  logic        int_pending;
  logic        exc_take;
  logic        eret_take;
  logic        mtc0_take;
  logic        flush_req;
  logic [31:0] target_pc;
  logic [31:0] rdata_reg;

  assign int_pending = inst_valid & status_ie & ~status_exl
                     & |({cause_ip_hw, cause_ip_sw} & status_im);

  // Highest-priority cause wins; all flags are don't-care for a bubble.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    exc_src  = SRC_NONE;
    exc_code = 5'd0;
    if (inst_valid) begin
      if (int_pending)      begin exc_src = SRC_INT;     exc_code = 5'd0;  end
      else if (exc_adel_if) begin exc_src = SRC_ADEL_IF; exc_code = 5'd4;  end
      else if (exc_ri)      begin exc_src = SRC_RI;      exc_code = 5'd10; end
      else if (exc_ov)      begin exc_src = SRC_OV;      exc_code = 5'd12; end
      else if (exc_sys)     begin exc_src = SRC_SYS;     exc_code = 5'd8;  end
      else if (exc_bp)      begin exc_src = SRC_BP;      exc_code = 5'd9;  end
      else if (exc_adel_ld) begin exc_src = SRC_ADEL_LD; exc_code = 5'd4;  end
      else if (exc_ades)    begin exc_src = SRC_ADES;    exc_code = 5'd5;  end
    end
  end

  assign exc_take  = ~rst & (exc_src != SRC_NONE);
  assign eret_take = ~rst & inst_valid & eret & ~exc_take;
  assign mtc0_take = ~rst & inst_valid & mtc0_we & ~exc_take;

  // Count advances on every second edge; an MTC0 to Count restarts the phase.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
      tick  <= 1'b0;
    end else if (mtc0_take && waddr == ADDR_COUNT) begin
      count <= wdata;
      tick  <= 1'b0;
    end else begin
      tick <= ~tick;
      if (tick) count <= count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else if (mtc0_take && waddr == ADDR_COMPARE) begin
      compare  <= wdata;
      cause_ti <= 1'b0;
    end else if (count == compare) begin
      cause_ti <= 1'b1;
    end
  end

  // Hardware interrupt lines are registered, so IP[15:10] lag the sources by one cycle.
  always_ff @(posedge clk) begin
    if (rst) cause_ip_hw <= 6'd0;
    else     cause_ip_hw <= {ext_int[5] | cause_ti, ext_int[4:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_im  <= 8'd0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (exc_take) begin
      status_exl <= 1'b1;
    end else begin
      if (mtc0_take && waddr == ADDR_STATUS) begin
        status_im  <= wdata[15:8];
        status_exl <= wdata[1];
        status_ie  <= wdata[0];
      end
      if (eret_take) status_exl <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_bd       <= 1'b0;
      cause_ip_sw    <= 2'd0;
      cause_exc_code <= 5'd0;
    end else if (exc_take) begin
      cause_exc_code <= exc_code;
      if (!status_exl) cause_bd <= in_delayslot;
    end else if (mtc0_take && waddr == ADDR_CAUSE) begin
      cause_ip_sw <= wdata[9:8];
    end
  end

  // A nested exception (EXL already set) keeps the original return point.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc <= 32'd0;
    end else if (exc_take) begin
      if (!status_exl) epc <= in_delayslot ? pc - 32'd4 : pc;
    end else if (mtc0_take && waddr == ADDR_EPC) begin
      epc <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                           badvaddr <= 32'd0;
    else if (exc_take && exc_src == SRC_ADEL_IF)       badvaddr <= pc;
    else if (exc_take && (exc_src == SRC_ADEL_LD ||
                          exc_src == SRC_ADES))        badvaddr <= bad_addr;
  end

  always_comb begin
    rdata_reg = 32'd0;
    case (raddr)
      ADDR_BADVADDR: rdata_reg = badvaddr;
      ADDR_COUNT:    rdata_reg = count;
      ADDR_COMPARE:  rdata_reg = compare;
      ADDR_STATUS:   rdata_reg = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
      ADDR_CAUSE:    rdata_reg = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                                  1'b0, cause_exc_code, 2'b00};
      ADDR_EPC:      rdata_reg = epc;
      default:       rdata_reg = 32'd0;
    endcase
  end

  // A committing MTC0 is forwarded so a same-cycle MFC0 sees the new value.
  assign rdata = (mtc0_take && waddr == raddr) ? wdata : rdata_reg;

  assign flush_req = exc_take | eret_take;
  assign target_pc = exc_take ? EXC_ENTRY : (eret_take ? epc : 32'd0);
  assign cp0_to_ctrl_bus = CP0_TO_CTRL_WD'({flush_req, target_pc});

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a register-level behavioural model.
module tb_cp0_reg;

  localparam logic [31:0] EXC_ENTRY = 32'hBFC0_0380;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        in_delayslot;
  logic        exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades;
  logic [31:0] bad_addr;
  logic        eret;
  logic        mtc0_we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  ext_int;
  logic [32:0] cp0_to_ctrl_bus;

  cp0_reg #(.EXC_ENTRY(EXC_ENTRY), .CP0_TO_CTRL_WD(33)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc), .in_delayslot(in_delayslot),
    .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_sys(exc_sys),
    .exc_bp(exc_bp), .exc_adel_ld(exc_adel_ld), .exc_ades(exc_ades), .bad_addr(bad_addr),
    .eret(eret), .mtc0_we(mtc0_we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .ext_int(ext_int), .cp0_to_ctrl_bus(cp0_to_ctrl_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (architectural register view) ----------------
  bit          m_valid = 0;
  logic [31:0] m_count, m_compare, m_epc, m_badv;
  bit          m_tick, m_ti, m_exl, m_ie, m_bd;
  logic [7:0]  m_im, m_ip;
  logic [4:0]  m_code;

  // Returns whether the current instruction excepts, its code and which cause won.
  function automatic void m_exc(output bit take, output logic [4:0] code, output int src);
    bit          flags [8];
    logic [4:0]  codes [8];
    flags = '{m_ie && !m_exl && ((m_ip & m_im) != 8'd0), exc_adel_if, exc_ri, exc_ov,
              exc_sys, exc_bp, exc_adel_ld, exc_ades};
    codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    take = 0; code = 5'd0; src = -1;
    if (!rst && inst_valid)
      for (int i = 0; i < 8; i++)
        if (flags[i] && !take) begin take = 1; code = codes[i]; src = i; end
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata();
    bit t; logic [4:0] c; int s;
    m_exc(t, c, s);
    if (!rst && inst_valid && mtc0_we && !t && waddr == raddr) return wdata;
    return m_read(raddr);
  endfunction

  function automatic logic [32:0] m_bus();
    bit t; logic [4:0] c; int s;
    m_exc(t, c, s);
    if (t) return {1'b1, EXC_ENTRY};
    if (!rst && inst_valid && eret) return {1'b1, m_epc};
    return 33'd0;
  endfunction

  always @(posedge clk) begin
    bit t, eret_ok, mtc, old_ti, old_exl;
    logic [4:0] c;
    logic [31:0] old_count;
    int s;
    if (rst) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_tick = 0; m_ti = 0;
      m_exl = 0; m_ie = 0; m_bd = 0; m_im = 0; m_ip = 0; m_code = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_exc(t, c, s);
      eret_ok   = inst_valid && eret && !t;
      mtc       = inst_valid && mtc0_we && !t;
      old_count = m_count;
      old_ti    = m_ti;
      old_exl   = m_exl;
      if (mtc && waddr == 5'd9) begin m_count = wdata; m_tick = 0; end
      else begin if (m_tick) m_count = m_count + 1; m_tick = !m_tick; end
      if (mtc && waddr == 5'd11) begin m_compare = wdata; m_ti = 0; end
      else if (old_count == m_compare) m_ti = 1;
      m_ip[7:2] = {ext_int[5] | old_ti, ext_int[4:0]};
      if (mtc) case (waddr)
        5'd12: begin m_im = wdata[15:8]; m_exl = wdata[1]; m_ie = wdata[0]; end
        5'd13: m_ip[1:0] = wdata[9:8];
        5'd14: m_epc = wdata;
        default: ;
      endcase
      if (eret_ok) m_exl = 0;
      if (t) begin
        if (!old_exl) begin m_epc = in_delayslot ? pc - 4 : pc; m_bd = in_delayslot; end
        m_exl  = 1;
        m_code = c;
        if (s == 1) m_badv = pc;
        else if (s == 6 || s == 7) m_badv = bad_addr;
      end
    end
  end

  // Combinational outputs are compared every cycle, mid-period, once the model is live.
  always @(negedge clk) begin
    if (m_valid) begin
      check("bus", 64'(cp0_to_ctrl_bus), 64'(m_bus()));
      check("rdata", 64'(rdata), 64'(m_rdata()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    inst_valid = 0; in_delayslot = 0; eret = 0; mtc0_we = 0;
    exc_adel_if = 0; exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
    exc_adel_ld = 0; exc_ades = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] v);
    raddr = a;
    #1;
    v = rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    inst_valid = 1; mtc0_we = 1; waddr = a; wdata = d;
    step();
    idle();
  endtask

  logic [31:0] v;
  bit          found;
  int          waddr_tbl [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
  int          raddr_tbl [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd20};

  initial begin
    idle();
    rst = 1; pc = 0; bad_addr = 0; waddr = 0; wdata = 0; raddr = 0; ext_int = 0;
    step(); step();
    rst = 0;

    // Reset then ten idle cycles
    repeat (10) step();
    peek(5'd9, v);  check("count_after_10", 64'(v), 64'd5);
    peek(5'd12, v); check("status_reset", 64'(v), 64'h0040_0000);
    check("bus_idle", 64'(cp0_to_ctrl_bus), 64'd0);

    // Syscall
    inst_valid = 1; pc = 32'h8000_0100; exc_sys = 1; #1;
    check("bus_sys", 64'(cp0_to_ctrl_bus), 64'({1'b1, 32'hBFC0_0380}));
    step(); idle();
    peek(5'd14, v); check("epc_sys", 64'(v), 64'h8000_0100);
    peek(5'd13, v); check("code_sys", 64'(v[6:2]), 64'd8);
    peek(5'd12, v); check("exl_sys", 64'(v[1]), 64'd1);

    // MTC0 bypass, then the same MTC0 suppressed by a reserved-instruction exception
    inst_valid = 1; mtc0_we = 1; waddr = 5'd14; wdata = 32'h1234; raddr = 5'd14; #1;
    check("bypass_epc", 64'(rdata), 64'h1234);
    step();
    wdata = 32'h5678; exc_ri = 1; #1;
    check("no_bypass_ri", 64'(rdata), 64'h1234);
    step(); idle();
    peek(5'd14, v); check("epc_kept_ri", 64'(v), 64'h1234);
    peek(5'd13, v); check("code_ri", 64'(v[6:2]), 64'd10);

    // ERET
    mtc0(5'd14, 32'h8000_0300);
    inst_valid = 1; eret = 1; #1;
    check("bus_eret", 64'(cp0_to_ctrl_bus), 64'({1'b1, 32'h8000_0300}));
    step(); idle();
    peek(5'd12, v); check("exl_after_eret", 64'(v[1]), 64'd0);

    // AdES in a delay slot
    inst_valid = 1; pc = 32'h8000_0204; in_delayslot = 1; exc_ades = 1; bad_addr = 32'h1;
    step(); idle();
    peek(5'd14, v); check("epc_ades", 64'(v), 64'h8000_0200);
    peek(5'd13, v); check("bd_code_ades", 64'({v[31], v[6:2]}), 64'({1'b1, 5'd5}));
    peek(5'd8, v);  check("badv_ades", 64'(v), 64'h1);
    inst_valid = 1; eret = 1; step(); idle();

    // Priority: overflow beats syscall and breakpoint
    inst_valid = 1; pc = 32'h8000_0500; exc_ov = 1; exc_sys = 1; exc_bp = 1;
    step(); idle();
    peek(5'd13, v); check("code_ov_prio", 64'(v[6:2]), 64'd12);
    inst_valid = 1; eret = 1; step(); idle();

    // Timer interrupt
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd6);
    mtc0(5'd12, 32'h0000_8001);
    peek(5'd12, v); check("status_written", 64'(v), 64'h0040_8001);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      peek(5'd13, v);
      if (v[30]) found = 1; else step();
    end
    check("ti_seen", 64'(found), 64'd1);
    peek(5'd9, v); check("count_at_ti", 64'(v), 64'd6);
    step(); step();
    inst_valid = 1; pc = 32'h8000_0400; #1;
    check("bus_timer_int", 64'(cp0_to_ctrl_bus), 64'({1'b1, 32'hBFC0_0380}));
    step(); idle();
    peek(5'd13, v); check("code_int", 64'(v[6:2]), 64'd0);
    peek(5'd14, v); check("epc_int", 64'(v), 64'h8000_0400);
    mtc0(5'd11, 32'hFFFF_0000);
    peek(5'd13, v); check("ti_cleared", 64'(v[30]), 64'd0);

    // ERET and a pending interrupt in the same cycle
    inst_valid = 1; eret = 1; #1;
    check("bus_eret_int_epc", 64'(cp0_to_ctrl_bus), 64'({1'b1, 32'h8000_0400}));
    step(); idle();
    ext_int = 6'b100000;
    step();
    inst_valid = 1; eret = 1; #1;
    check("bus_eret_vs_int", 64'(cp0_to_ctrl_bus), 64'({1'b1, 32'hBFC0_0380}));
    step(); idle(); ext_int = 6'd0;
    peek(5'd12, v); check("exl_int_wins", 64'(v[1]), 64'd1);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 4000; n++) begin
      idle();
      rst          = ($urandom_range(0, 299) == 0);
      inst_valid   = ($urandom_range(0, 9) < 7);
      pc           = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      in_delayslot = $urandom_range(0, 3) == 0;
      bad_addr     = $urandom;
      if (inst_valid) begin
        exc_adel_if = $urandom_range(0, 29) == 0;
        exc_ri      = $urandom_range(0, 29) == 0;
        exc_ov      = $urandom_range(0, 29) == 0;
        exc_sys     = $urandom_range(0, 29) == 0;
        exc_bp      = $urandom_range(0, 29) == 0;
        exc_adel_ld = $urandom_range(0, 29) == 0;
        exc_ades    = $urandom_range(0, 29) == 0;
        eret        = $urandom_range(0, 7) == 0;
        mtc0_we     = $urandom_range(0, 3) == 0;
      end
      waddr = 5'(waddr_tbl[$urandom_range(0, 4)]);
      wdata = (waddr == 5'd9 || waddr == 5'd11) ? $urandom_range(0, 20) : $urandom;
      raddr = 5'(raddr_tbl[$urandom_range(0, 7)]);
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom_range(0, 63));
      step();
    end
    rst = 0; idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
